// File: rtl/pcl.sv
// Program counter low byte: PCL source select, +1 increment, PCL register,
// pending carry into the high stage and ADL/DB bus drivers.
module pcl #(
  parameter logic [7:0] RESET_PCL = 8'h00
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_pcl_pcl,
  input  logic       i_adl_pcl,
  input  logic [7:0] i_adl,
  input  logic       i_i_pc,
  input  logic       i_pch_update,
  input  logic       i_pcl_adl,
  input  logic       i_pcl_db,
  output logic [7:0] o_pcl,
  output logic       o_pclc,
  output logic [7:0] o_adl,
  output logic [7:0] o_db
);

  localparam int unsigned W = 8;

  logic [W-1:0] r_pcl;
  logic         carry;
  logic [W-1:0] pcls;
  logic [W:0]   sum;
  logic [W-1:0] next_pcl;
  logic         wrap;

  // Source select: current PCL has priority over ADL; neither selects zero.
  always_comb begin
    pcls = '0;
    if (i_pcl_pcl) begin
      pcls = r_pcl;
    end else if (i_adl_pcl) begin
      pcls = i_adl;
    end
  end

  always_comb begin
    sum      = {1'b0, pcls} + (W+1)'(i_i_pc);
    next_pcl = sum[W-1:0];
    wrap     = sum[W];
  end

  // A wrap on the same edge the high stage consumes the old carry leaves a new one pending.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_pcl <= RESET_PCL;
      carry <= 1'b0;
    end else begin
      r_pcl <= next_pcl;
      if (wrap) begin
        carry <= 1'b1;
      end else if (i_pch_update) begin
        carry <= 1'b0;
      end
    end
  end

  assign o_pcl  = r_pcl;
  assign o_pclc = carry;
  assign o_adl  = i_pcl_adl ? r_pcl : 8'h00;
  assign o_db   = i_pcl_db  ? r_pcl : 8'h00;

endmodule

// File: doc/pcl.md
Name: pcl

Overview:
- Program Counter Low stage for the cpu6502 datapath: select (PCLS), increment logic and PCL register.
- Sits directly upstream of the program counter high stage. It supplies the low-byte carry on o_pclc, which feeds the high stage's i_pclc input.
- Holds the carry from a low-byte wrap in a pending flag until the high stage signals that it has consumed it.
- Drives the current low byte onto ADL and DB when enabled.

Parameters:
RESET_PCL, 8'h00, value loaded into the PCL register on reset

Ports:
i_clk  input  1  clock; all state updates on rising edge
i_reset_n  input  1  reset; asynchronous, active-low
i_pcl_pcl  input  1  control: PCLS selects current PCL
i_adl_pcl  input  1  control: PCLS selects i_adl
i_adl  input  8  ADL bus value
i_i_pc  input  1  control: increment selected value by 1
i_pch_update  input  1  high stage is updating this cycle and consumes o_pclc
i_pcl_adl  input  1  control: drive PCL onto ADL
i_pcl_db  input  1  control: drive PCL onto DB
o_pcl  output  8  PCL register value
o_pclc  output  1  pending carry into the high stage
o_adl  output  8  PCL when i_pcl_adl, else 8'h00
o_db  output  8  PCL when i_pcl_db, else 8'h00

Behaviour:
- Reset (i_reset_n low, asynchronous, any time including mid-operation):
  - r_pcl = RESET_PCL; pending carry = 0.
  - o_pcl = RESET_PCL; o_pclc = 0.
  - o_adl and o_db follow their combinational rule using the reset PCL value.
  - The first rising edge after release applies normal update rules.
- PCLS (combinational), fixed priority:
  - i_pcl_pcl high: select r_pcl (wins if both selects are high).
  - else i_adl_pcl high: select i_adl.
  - else: select 8'h00.
- Increment (combinational):
  - sum = {1'b0, pcls} + i_i_pc, 9 bits wide.
  - next_pcl = sum[7:0]; wrap = sum[8].
  - wrap is 1 only when pcls == 8'hFF and i_i_pc == 1.
- Register: r_pcl <= next_pcl on every rising edge; latency 1 cycle from the select/increment controls to o_pcl.
- Pending carry flag c, evaluated per rising edge:
  - wrap=1: c <= 1. A simultaneous i_pch_update clears the old carry and sets the new one, so the net result is 1.
  - wrap=0 and i_pch_update=1: c <= 0.
  - otherwise c holds.
- o_pclc = c, registered with no combinational path from inputs. The high stage sees the carry on the cycle after the wrap edge and must apply it on its next update.
- Bus drivers are combinational from r_pcl and do not affect state. Both may be enabled at once.
- Wrap-around: 8'hFF with increment gives 8'h00 and sets carry. 8'hFF without increment holds 8'hFF and leaves carry unchanged.
- Loading 8'hFF from ADL with increment in the same cycle also wraps and sets carry.

Test Plan:
- Reset:
  - Stimulus: RESET_PCL=8'h00; assert i_reset_n low asynchronously between edges.
  - Required: o_pcl=00 and o_pclc=0 immediately, without waiting for an edge.
  - Stimulus: apply a mid-count reset while c=1.
  - Required: c clears and o_pcl returns to 00.
- Sequential increment:
  - Stimulus: i_pcl_pcl=1, i_i_pc=1 for 3 edges from 8'hFD.
  - Required: o_pcl goes FE, FF, 00.
  - Required: o_pclc rises to 1 after the third edge and is held while i_pch_update=0.
- Carry consume and overlap:
  - Stimulus: with c=1, pulse i_pch_update for one edge with no wrap.
  - Required: o_pclc=0 after that edge.
  - Stimulus: repeat with wrap on the same edge as i_pch_update.
  - Required: o_pclc stays 1.
- ADL load:
  - Stimulus: i_adl_pcl=1, i_adl=8'h42, i_i_pc=0.
  - Required: o_pcl=42 next cycle.
  - Stimulus: i_adl=8'hFF, i_i_pc=1.
  - Required: o_pcl=00 and o_pclc=1.
- Select priority and defaults:
  - Stimulus: i_pcl_pcl=1 and i_adl_pcl=1, r_pcl=10, i_adl=80, i_i_pc=0.
  - Required: o_pcl stays 10.
  - Stimulus: both selects low, i_i_pc=1.
  - Required: o_pcl=01, no carry.
- Bus drive:
  - Stimulus: r_pcl=5A with i_pcl_adl=1 and i_pcl_db=0.
  - Required: o_adl=5A, o_db=00.
  - Stimulus: toggle the enables.
  - Required: outputs swap in the same cycle, and o_pcl is unaffected.
